// File: rtl/screen_pkg.sv
// Shared screen-buffer constants, clear FSM states and the CPU write entry format.
// Used by the write arbiter, display fetch and prefetch logic.
package screen_pkg;

  localparam int SCREEN_PIX_BYTES = 6144;
  localparam int SCREEN_BYTES     = 6912;
  localparam int SCREEN_AW        = 13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_PIX  = 2'd1,
    ST_CLR_ATTR = 2'd2
  } clr_state_e;

  typedef struct packed {
    logic [SCREEN_AW-1:0] addr;
    logic [7:0]           data;
  } wr_entry_t;

endpackage

// File: rtl/screen_write_arbiter_if.sv
// CPU write, clear control and buffer write-port signals of the screen write arbiter.
// master drives the request side; slave is the arbiter.
interface screen_write_arbiter_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        slot_en;
  logic        clr_start;
  logic [7:0]  clr_attr;
  logic        ovf_clr;
  logic [7:0]  buf_write;
  logic [12:0] buf_write_addr;
  logic        buf_we;
  logic        clr_busy;
  logic        fifo_ovf;

  modport master (
    output cpu_addr, cpu_data, cpu_wr, slot_en, clr_start, clr_attr, ovf_clr,
    input  buf_write, buf_write_addr, buf_we, clr_busy, fifo_ovf
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_wr, slot_en, clr_start, clr_attr, ovf_clr,
    output buf_write, buf_write_addr, buf_we, clr_busy, fifo_ovf
  );

endinterface

// File: rtl/screen_write_arbiter_wr_fifo.sv
// CPU write queue: registered pointers, combinational head, no bypass (push visible next cycle).
// Caller must not push when full unless popping in the same cycle, nor pop when empty.
module wr_fifo
  import screen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t push_dat,
  input  logic      pop,
  output wr_entry_t pop_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wr_entry_t   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/screen_write_arbiter.sv
// Shares the screen buffer write port between queued CPU writes (strict priority) and the clear engine.
// Registered outputs, CPU write reaches buf_we one slot after push at best; full queue drops and flags fifo_ovf.
module screen_write_arbiter
  import screen_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] SCREEN_BASE = 16'h4000
) (
  input logic                   clk,
  input logic                   rst_n,
  screen_write_arbiter_if.slave bus
);

  localparam logic [1:0]  IDLE     = ST_IDLE;
  localparam logic [1:0]  CLR_PIX  = ST_CLR_PIX;
  localparam logic [1:0]  CLR_ATTR = ST_CLR_ATTR;
  localparam logic [16:0] ADDR_LO  = {1'b0, SCREEN_BASE};
  localparam logic [16:0] ADDR_HI  = ADDR_LO + 17'(SCREEN_BYTES);
  localparam logic [12:0] BASE_LO  = SCREEN_BASE[12:0];
  localparam logic [12:0] PIX_LAST = 13'(SCREEN_PIX_BYTES - 1);
  localparam logic [12:0] SCR_LAST = 13'(SCREEN_BYTES - 1);

  logic        in_range;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  logic        clr_gnt;
  wr_entry_t   cpu_entry;
  wr_entry_t   head;

  logic [1:0]  state;
  logic [12:0] clr_ptr;
  logic [7:0]  attr_q;
  logic        busy_q;
  logic        we_q;
  logic [12:0] addr_q;
  logic [7:0]  data_q;
  logic        ovf_q;

  assign in_range = ({1'b0, bus.cpu_addr} >= ADDR_LO) && ({1'b0, bus.cpu_addr} < ADDR_HI);
  assign accept   = bus.cpu_wr && in_range;
  // Offset only needs its low 13 bits, so subtract in 13-bit arithmetic.
  assign cpu_entry.addr = bus.cpu_addr[12:0] - BASE_LO;
  assign cpu_entry.data = bus.cpu_data;

  assign pop     = bus.slot_en && !empty;
  assign push    = accept && (!full || pop);
  assign drop    = accept && full && !pop;
  assign clr_gnt = bus.slot_en && empty && (state != IDLE);

  wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (cpu_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  // Clear FSM: pointer moves only on its own grants, so CPU traffic never skips an address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_ptr <= '0;
      attr_q  <= '0;
      busy_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.clr_start) begin
        state   <= CLR_PIX;
        clr_ptr <= '0;
        attr_q  <= bus.clr_attr;
        busy_q  <= 1'b1;
      end
    end else if (clr_gnt) begin
      clr_ptr <= clr_ptr + 13'd1;
      if (state == CLR_PIX && clr_ptr == PIX_LAST) begin
        state <= CLR_ATTR;
      end
      if (state == CLR_ATTR && clr_ptr == SCR_LAST) begin
        state   <= IDLE;
        clr_ptr <= '0;
        busy_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= pop || clr_gnt;
      if (pop) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end else if (clr_gnt) begin
        addr_q <= clr_ptr;
        data_q <= (state == CLR_PIX) ? 8'h00 : attr_q;
      end
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.buf_we         = we_q;
  assign bus.buf_write_addr = addr_q;
  assign bus.buf_write      = data_q;
  assign bus.clr_busy       = busy_q;
  assign bus.fifo_ovf       = ovf_q;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Scoreboard bench for screen_write_arbiter: CPU writes queued with their due cycle, clear writes tracked by pointer.
module tb_screen_write_arbiter;
  import screen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_write_arbiter_if bus ();

  screen_write_arbiter #(.FIFO_DEPTH(4), .SCREEN_BASE(16'h4000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          due;
    bit          lat;
  } exp_t;

  exp_t       cpu_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         clr_expect = 0;
  int         clr_ptr_exp = 0;
  logic [7:0] attr_exp = 8'h00;
  int         clr_wr_cnt = 0;
  int         cpu_wr_cnt = 0;
  int         cpu1800_cyc = 0;
  int         clr1800_cyc = 0;
  logic [7:0] mem [SCREEN_BYTES];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A queued CPU write that is due must win the port; anything else must be the next clear address.
  always @(negedge clk) begin
    if (rst_n && bus.buf_we === 1'b1) begin
      if (int'(bus.buf_write_addr) < SCREEN_BYTES) mem[bus.buf_write_addr] = bus.buf_write;
      if (cpu_q.size() > 0 && cyc >= cpu_q[0].due) begin
        mon_e = cpu_q.pop_front();
        chk("cpu_addr", bus.buf_write_addr, mon_e.addr);
        chk("cpu_data", bus.buf_write, mon_e.data);
        if (mon_e.lat) chk("cpu_lat", cyc, mon_e.due);
        if (bus.buf_write_addr == 13'h1800) cpu1800_cyc = cyc;
        cpu_wr_cnt++;
      end else if (clr_expect) begin
        chk("clr_addr", bus.buf_write_addr, clr_ptr_exp);
        chk("clr_data", bus.buf_write, (clr_ptr_exp < 6144) ? 8'h00 : attr_exp);
        chk("clr_busy", bus.clr_busy, clr_ptr_exp != 6911);
        if (clr_ptr_exp == 6144) clr1800_cyc = cyc;
        clr_wr_cnt++;
        clr_ptr_exp++;
        if (clr_ptr_exp == SCREEN_BYTES) clr_expect = 0;
      end else begin
        chk("unexp_we", bus.buf_we, 1'b0);
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit acc, input bit lat);
    exp_t e;
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_data = d;
    bus.cpu_wr   = 1'b1;
    if (acc) begin
      e.addr = 13'(a - 16'h4000);
      e.data = d;
      e.due  = cyc + 2;
      e.lat  = lat;
      cpu_q.push_back(e);
    end
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((cpu_q.size() != 0 || clr_expect) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < limit, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_clr_ptr(input int target, input int limit);
    int n = 0;
    while (clr_ptr_exp < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("clr_ptr_timeout", n < limit, 1'b1);
  endtask

  task automatic start_clear(input logic [7:0] attr);
    @(negedge clk);
    bus.clr_attr  = attr;
    bus.clr_start = 1'b1;
    clr_expect    = 1;
    clr_ptr_exp   = 0;
    attr_exp      = attr;
    clr_wr_cnt    = 0;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.clr_attr  = 8'h00;
  endtask

  int base_cnt;

  initial begin
    bus.cpu_addr  = 16'h0000;
    bus.cpu_data  = 8'h00;
    bus.cpu_wr    = 1'b0;
    bus.slot_en   = 1'b0;
    bus.clr_start = 1'b0;
    bus.clr_attr  = 8'h00;
    bus.ovf_clr   = 1'b0;
    for (int i = 0; i < SCREEN_BYTES; i++) mem[i] = 8'hEE;

    #12;
    chk("rst_we", bus.buf_we, 1'b0);
    chk("rst_addr", bus.buf_write_addr, 13'h0);
    chk("rst_data", bus.buf_write, 8'h00);
    chk("rst_busy", bus.clr_busy, 1'b0);
    chk("rst_ovf", bus.fifo_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.slot_en = 1'b1;

    // Single write
    cpu_write(16'h4000, 8'hAA, 1, 1);
    wait_idle(50);
    chk("single_cnt", cpu_wr_cnt, 1);

    // Decode bounds
    base_cnt = cpu_wr_cnt;
    cpu_write(16'h3FFF, 8'h01, 0, 0);
    cpu_write(16'h5B00, 8'h02, 0, 0);
    cpu_write(16'h5AFF, 8'h11, 1, 1);
    wait_idle(50);
    chk("decode_cnt", cpu_wr_cnt - base_cnt, 1);
    chk("decode_ovf", bus.fifo_ovf, 1'b0);
    chk("decode_mem", mem[13'h1AFF], 8'h11);

    // Overflow with the slot stalled
    base_cnt = cpu_wr_cnt;
    bus.slot_en = 1'b0;
    for (int i = 1; i <= 5; i++) cpu_write(16'(16'h4000 + i), 8'(i), i <= 4, 0);
    chk("ovf_set", bus.fifo_ovf, 1'b1);
    @(negedge clk) bus.ovf_clr = 1'b1;
    @(negedge clk) bus.ovf_clr = 1'b0;
    chk("ovf_clr", bus.fifo_ovf, 1'b0);
    @(negedge clk);
    bus.cpu_addr = 16'h4006;
    bus.cpu_data = 8'h06;
    bus.cpu_wr   = 1'b1;
    bus.ovf_clr  = 1'b1;
    @(negedge clk);
    bus.cpu_wr  = 1'b0;
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", bus.fifo_ovf, 1'b1);
    chk("ovf_no_we", bus.buf_we, 1'b0);
    bus.slot_en = 1'b1;
    wait_idle(50);
    chk("ovf_cnt", cpu_wr_cnt - base_cnt, 4);
    chk("ovf_sticky", bus.fifo_ovf, 1'b1);
    @(negedge clk) bus.ovf_clr = 1'b1;
    @(negedge clk) bus.ovf_clr = 1'b0;
    chk("ovf_clr2", bus.fifo_ovf, 1'b0);

    // Full clear with an ignored restart and a CPU write in contention
    base_cnt = cpu_wr_cnt;
    start_clear(8'h38);
    chk("clr_busy_start", bus.clr_busy, 1'b1);
    wait_clr_ptr(1000, 2000);
    @(negedge clk);
    bus.clr_attr  = 8'hFF;
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.clr_attr  = 8'h00;
    wait_clr_ptr(3000, 4000);
    cpu_write(16'h5800, 8'h47, 1, 1);
    wait_idle(10000);
    chk("clr_total", clr_wr_cnt, SCREEN_BYTES);
    chk("clr_cpu_cnt", cpu_wr_cnt - base_cnt, 1);
    chk("clr_busy_end", bus.clr_busy, 1'b0);
    chk("mem_1800", mem[13'h1800], (clr1800_cyc > cpu1800_cyc) ? 8'h38 : 8'h47);
    chk("mem_0000", mem[0], 8'h00);
    chk("mem_1AFF", mem[13'h1AFF], 8'h38);

    // Reset mid-clear
    start_clear(8'h38);
    wait_clr_ptr(100, 500);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clr_expect = 0;
    cpu_q.delete();
    #1;
    chk("arst_we", bus.buf_we, 1'b0);
    chk("arst_addr", bus.buf_write_addr, 13'h0);
    chk("arst_data", bus.buf_write, 8'h00);
    chk("arst_busy", bus.clr_busy, 1'b0);
    chk("arst_ovf", bus.fifo_ovf, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", bus.clr_busy, 1'b0);
    base_cnt = cpu_wr_cnt;
    cpu_write(16'h4010, 8'h5A, 1, 1);
    wait_idle(50);
    chk("post_rst_cpu", cpu_wr_cnt - base_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_write_arbiter.md
# screen_write_arbiter

Shares the single write port of the 6912-byte ZX screen buffer between two requesters: Z80 memory writes that hit the screen region, and a bulk clear engine (CLS / reset fill). CPU writes are address-decoded, queued in a small FIFO and drained one per write slot. The clear engine uses the remaining slots. The block drives the buffer's `buf_write` / `buf_write_addr` / `buf_we` port.

## Interface
- `FIFO_DEPTH`, 4: CPU write queue entries; power of two, ≥2.
- `SCREEN_BASE`, 16'h4000: CPU address of buffer byte 0.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `cpu_addr  in  16`: CPU write address.
- `cpu_data  in  8`: CPU write data.
- `cpu_wr  in  1`: one-cycle write strobe; at most one per write.
- `slot_en  in  1`: write slot available this cycle (paced to the buffer write clock).
- `clr_start  in  1`: one-cycle pulse to start a clear.
- `clr_attr  in  8`: attribute byte for the clear; sampled at `clr_start`.
- `ovf_clr  in  1`: clears `fifo_ovf`.
- `buf_write  out  8`: write data.
- `buf_write_addr  out  13`: write address, 0–6911.
- `buf_we  out  1`: write strobe, one cycle per write.
- `clr_busy  out  1`: clear in progress.
- `fifo_ovf  out  1`: sticky flag; a CPU write was dropped.

## Operation
- **Decode.** A write is accepted only when `SCREEN_BASE ≤ cpu_addr < SCREEN_BASE+6912`. Its buffer address is `cpu_addr − SCREEN_BASE`, truncated to 13 bits. Out-of-range writes are ignored and do not set the flag.
- **Push.** An accepted write is pushed when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and `fifo_ovf` is set.
  - `fifo_ovf` stays set until `ovf_clr`. If set and clear happen together, set wins.
- **Clear FSM** states:
  - IDLE → CLR_PIX on `clr_start`. This sets `clr_ptr`=0 and latches `clr_attr`.
  - CLR_PIX writes data 8'h00 to addresses 0–6143. After address 6143 is granted it moves to CLR_ATTR.
  - CLR_ATTR writes the latched attribute to addresses 6144–6911. After address 6911 is granted it returns to IDLE.
  - `clr_start` is ignored outside IDLE.
  - `clr_busy` = (state ≠ IDLE).
- **Arbitration**, evaluated each cycle with `slot_en`=1:
  - FIFO non-empty: pop the head and grant it to the CPU.
  - FIFO empty and clear busy: grant the clear engine and increment `clr_ptr`.
  - Neither: no grant.
  - Strict CPU priority applies. The clear pointer advances only on its own grants, so no clear address is skipped.
- **Write ordering.** CPU writes leave in push order. Each clear address is written exactly once per clear.
- **Width.** `clr_ptr` is 13 bits and never exceeds 6911.

## Timing
- All outputs are registered.
- A grant at edge N drives `buf_we`=1 with address and data during cycle N→N+1. With no grant, `buf_we`=0 and address/data hold their last values.
- **Latency.** `cpu_wr` sampled at edge N is pushed at N. It is popped at the earliest slot at edge ≥ N+1 (no bypass), so `buf_we` is high after edge N+1 at best.
- A clear finishes within 6912 plus (CPU writes granted meanwhile) slot cycles. `clr_busy` falls on the edge that grants address 6911, together with that `buf_we`.
- `slot_en`=0 stalls everything. The FIFO fills and then drops.
- **Reset** (asynchronous, immediate), including mid-clear, which aborts:
  - `buf_we`=0, `buf_write`=0, `buf_write_addr`=0.
  - `clr_busy`=0, `fifo_ovf`=0.
  - FIFO empty, FSM in IDLE.

## Structure
- **Package `screen_pkg`:**
  - `SCREEN_PIX_BYTES`=6144, `SCREEN_BYTES`=6912.
  - Clear FSM state enum (IDLE, CLR_PIX, CLR_ATTR).
  - Shared with the display and prefetch logic.
- **Sub-module `wr_fifo`:** synchronous FIFO of 21-bit entries (address 13 + data 8).
  - Ports: push, pop, full, empty; depth = `FIFO_DEPTH`.
  - Simultaneous push and pop are legal when full.

## Test plan
- **Single write:** `slot_en`=1 every cycle, write 0x4000/0xAA → one `buf_we` pulse with addr 0x0000, data 0xAA, two edges after `cpu_wr`.
- **Decode bounds:** writes to 0x3FFF, 0x5B00, 0x5AFF/0x11 → only one write, addr 0x1AFF data 0x11; `fifo_ovf` stays 0.
- **Overflow:** `slot_en`=0, five writes (0x4001–0x4005, data 1–5), then `slot_en`=1 → four writes, addrs 1–4 in order; `fifo_ovf`=1 until `ovf_clr`.
- **Full clear:** `clr_attr`=0x38, `slot_en`=1 → 6912 pulses.
  - Addrs 0–6143 carry data 0x00; addrs 6144–6911 carry data 0x38.
  - `clr_busy` falls with the last pulse.
  - A second `clr_start` sent mid-clear is ignored.
- **Contention:** CPU write 0x5800/0x47 mid-clear → it is granted at the next slot. The clear then resumes at the next unwritten address, still 6912 clear writes total. Memory model check: 0x1800 = 0x38 if the clear reached it after the CPU write, otherwise 0x47.
- **Reset mid-clear:** assert `rst_n`=0 at clear address 100 → outputs reset asynchronously; after release, no `buf_we` until a new `clr_start` or CPU write.
